// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the regfile_2r1w register file.
//   - default reset values for the UART configuration and clock-divider entries
//   - indices of the exported configuration registers
//   - even-parity helper used by the optional parity protection
//     (REGFILE_PARITY_CHECK_EN)
package regfile_pkg;

    // Entry 2: parity enabled, even parity, prescale field.
    localparam logic [7:0] RST_REG2_DEFAULT = 8'b1000_0001;
    // Entry 3: clock divider ratio 32.
    localparam logic [7:0] RST_REG3_DEFAULT = 8'b0010_0000;

    // Exported register map, shared with the ALU/UART/divider blocks.
    localparam int unsigned REG_ALU_A     = 32'd0;
    localparam int unsigned REG_ALU_B     = 32'd1;
    localparam int unsigned REG_UART_CFG  = 32'd2;
    localparam int unsigned REG_DIV_RATIO = 32'd3;

    // Widest data word the parity helper accepts. Callers zero-extend their
    // word to this width, which leaves the parity unchanged.
    localparam int unsigned PARITY_MAX_W = 32'd64;

    // Even-parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of regfile_2r1w.
// Handles address range check, write-first bypass, output/valid registers and
// (with REGFILE_PARITY_CHECK_EN) the parity check of the stored word.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rd_en_i/rd_addr_i read strobe and address
//   wr_*_i            write port of the same cycle, used for the bypass
//   mem_i             current storage contents
//   par_i             stored parity bits (parity build only)
//   rd_data_o         registered read data, holds when no read is issued
//   rd_valid_o        one-cycle pulse per read strobe
//   addr_err_o        pulses with rd_valid_o for an out-of-range address
//   par_err_o         pulses with rd_valid_o for a parity mismatch (0 otherwise)
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR      = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_en_i,
    input  logic [ADDR-1:0]      rd_addr_i,
    input  logic                 wr_en_i,
    input  logic [ADDR-1:0]      wr_addr_i,
    input  logic [DATAWIDTH-1:0] wr_data_i,
    input  logic [DATAWIDTH-1:0] mem_i [DEPTH],
`ifdef REGFILE_PARITY_CHECK_EN
    input  logic                 par_i [DEPTH],
`endif
    output logic [DATAWIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 addr_err_o,
    output logic                 par_err_o
);

    logic                 in_range_s;
    logic                 bypass_s;
    logic [DATAWIDTH-1:0] data_d,  data_q;
    logic                 valid_d, valid_q;
    logic                 aerr_d,  aerr_q;
    logic                 perr_d;

    // Next-state for the read data, valid and error pulses.
    always_comb begin
        in_range_s = (32'(rd_addr_i) < 32'(DEPTH));
        // An out-of-range write can only match an out-of-range read, which
        // returns 0 anyway, so only in-range matches need the bypass.
        bypass_s   = wr_en_i && (wr_addr_i == rd_addr_i) && in_range_s;
        data_d     = data_q;
        valid_d    = 1'b0;
        aerr_d     = 1'b0;
        perr_d     = 1'b0;
        if (rd_en_i) begin
            valid_d = 1'b1;
            if (!in_range_s) begin
                data_d = '0;
                aerr_d = 1'b1;
            end else if (bypass_s) begin
                // Bypassed data never came from storage: no parity check.
                data_d = wr_data_i;
            end else begin
                data_d = mem_i[rd_addr_i];
`ifdef REGFILE_PARITY_CHECK_EN
                perr_d = (even_parity(PARITY_MAX_W'(mem_i[rd_addr_i])) != par_i[rd_addr_i]);
`endif
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output and pulse registers; reset cancels any pending valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            aerr_q  <= aerr_d;
        end
    end

`ifdef REGFILE_PARITY_CHECK_EN
    logic perr_q;

    // Parity error pulse register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign par_err_o = perr_q;
`else
    // perr_d stays 0 without parity storage; the flag is a constant.
    assign par_err_o = 1'b0;
`endif

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;
    assign addr_err_o = aerr_q;

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with one synchronous write port and two
// independent registered read ports (A: system controller, B: debug master).
// Optional feature macro: REGFILE_PARITY_CHECK_EN (per-entry even parity).
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   WrEn/WrAddr/WrData     write port
//   RdEnA/RdAddrA          port A read request -> RdDataA, RdValidA
//   RdEnB/RdAddrB          port B read request -> RdDataB, RdValidB
//   AddrErr[2:0]           out-of-range pulses {port B, port A, write}
//   ParErr[1:0]            parity-error pulses {port B, port A}
//   REG_OUT                entries 0..NUM_EXPORT-1, entry i at [i*DATAWIDTH +: DATAWIDTH]
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   DEPTH      = 16,
    parameter int                   ADDR       = 4,
    parameter int                   NUM_EXPORT = 4,
    parameter logic [DATAWIDTH-1:0] RST_REG2   = DATAWIDTH'(RST_REG2_DEFAULT),
    parameter logic [DATAWIDTH-1:0] RST_REG3   = DATAWIDTH'(RST_REG3_DEFAULT)
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            WrEn,
    input  logic [ADDR-1:0]                 WrAddr,
    input  logic [DATAWIDTH-1:0]            WrData,
    input  logic                            RdEnA,
    input  logic [ADDR-1:0]                 RdAddrA,
    output logic [DATAWIDTH-1:0]            RdDataA,
    output logic                            RdValidA,
    input  logic                            RdEnB,
    input  logic [ADDR-1:0]                 RdAddrB,
    output logic [DATAWIDTH-1:0]            RdDataB,
    output logic                            RdValidB,
    output logic [2:0]                      AddrErr,
    output logic [1:0]                      ParErr,
    output logic [NUM_EXPORT*DATAWIDTH-1:0] REG_OUT
);

    // Reset contents: only the UART configuration and divider entries are
    // non-zero. Using a lookup instead of fixed indices keeps DEPTH < 4 legal.
    function automatic logic [DATAWIDTH-1:0] rst_value(input int unsigned idx);
        case (idx)
            REG_UART_CFG:  rst_value = RST_REG2;
            REG_DIV_RATIO: rst_value = RST_REG3;
            default:       rst_value = '0;
        endcase
    endfunction

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [DATAWIDTH-1:0] mem_d [DEPTH];
    logic                 wr_in_range_s;
    logic                 wr_err_d, wr_err_q;
    logic                 rd_aerr_a_s, rd_aerr_b_s;
    logic                 par_err_a_s, par_err_b_s;

`ifdef REGFILE_PARITY_CHECK_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];
`endif

    // Write decode: in-range writes update storage, others flag an error.
    always_comb begin
        wr_in_range_s = (32'(WrAddr) < 32'(DEPTH));
        mem_d         = mem_q;
`ifdef REGFILE_PARITY_CHECK_EN
        par_d         = par_q;
`endif
        wr_err_d      = 1'b0;
        if (WrEn) begin
            if (wr_in_range_s) begin
                mem_d[WrAddr] = WrData;
`ifdef REGFILE_PARITY_CHECK_EN
                par_d[WrAddr] = even_parity(PARITY_MAX_W'(WrData));
`endif
            end else begin
                wr_err_d = 1'b1;
            end
        end else begin
            wr_err_d = 1'b0;
        end
    end

    // Storage and write-error register; reset wins over any write strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= rst_value(i);
            end
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_err_q <= wr_err_d;
        end
    end

`ifdef REGFILE_PARITY_CHECK_EN
    // Parity storage, reset to match the reset contents.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= even_parity(PARITY_MAX_W'(rst_value(i)));
            end
        end else begin
            par_q <= par_d;
        end
    end
`endif

    regfile_rd_port #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .ADDR      (ADDR)
    ) u_rd_port_a (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_en_i    (RdEnA),
        .rd_addr_i  (RdAddrA),
        .wr_en_i    (WrEn),
        .wr_addr_i  (WrAddr),
        .wr_data_i  (WrData),
        .mem_i      (mem_q),
`ifdef REGFILE_PARITY_CHECK_EN
        .par_i      (par_q),
`endif
        .rd_data_o  (RdDataA),
        .rd_valid_o (RdValidA),
        .addr_err_o (rd_aerr_a_s),
        .par_err_o  (par_err_a_s)
    );

    regfile_rd_port #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .ADDR      (ADDR)
    ) u_rd_port_b (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_en_i    (RdEnB),
        .rd_addr_i  (RdAddrB),
        .wr_en_i    (WrEn),
        .wr_addr_i  (WrAddr),
        .wr_data_i  (WrData),
        .mem_i      (mem_q),
`ifdef REGFILE_PARITY_CHECK_EN
        .par_i      (par_q),
`endif
        .rd_data_o  (RdDataB),
        .rd_valid_o (RdValidB),
        .addr_err_o (rd_aerr_b_s),
        .par_err_o  (par_err_b_s)
    );

    assign AddrErr = {rd_aerr_b_s, rd_aerr_a_s, wr_err_q};
    assign ParErr  = {par_err_b_s, par_err_a_s};

    // Export straight from storage: new data appears after the write edge,
    // with no bypass of the in-flight write.
    for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
        assign REG_OUT[g*DATAWIDTH +: DATAWIDTH] = mem_q[g];
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w. Two instances share the stimulus:
// dut0 with the default DEPTH=16 and dut12 with DEPTH=12 (out-of-range cases).
module tb_regfile_2r1w;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WrEn;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       RdEnA, RdEnB;
    logic [3:0] RdAddrA, RdAddrB;

    logic [7:0]  rda [2];
    logic [7:0]  rdb [2];
    logic        va  [2];
    logic        vb  [2];
    logic [2:0]  aerr [2];
    logic [1:0]  perr [2];
    logic [31:0] regout [2];

    int n_pass  = 0;
    int n_check = 0;

    always #5 CLK = ~CLK;

    regfile_2r1w dut0 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rda[0]), .RdValidA(va[0]),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rdb[0]), .RdValidB(vb[0]),
        .AddrErr(aerr[0]), .ParErr(perr[0]), .REG_OUT(regout[0])
    );

    regfile_2r1w #(.DEPTH(12)) dut12 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rda[1]), .RdValidA(va[1]),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rdb[1]), .RdValidB(vb[1]),
        .AddrErr(aerr[1]), .ParErr(perr[1]), .REG_OUT(regout[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         depth [2] = '{16, 12};
    logic [7:0] m  [2][16];
    logic       mp [2][16];
    logic [7:0] e_rda [2];
    logic [7:0] e_rdb [2];
    logic       e_va [2];
    logic       e_vb [2];
    logic [2:0] e_aerr [2];
    logic [1:0] e_perr [2];
    logic       mvalid = 1'b0;

    task automatic model_read(input int k, input logic [3:0] addr,
                              output logic [7:0] data, output logic ae, output logic pe);
        ae = 1'b0;
        pe = 1'b0;
        if (int'(addr) >= depth[k]) begin
            data = 8'h00;
            ae   = 1'b1;
        end else if (WrEn && WrAddr == addr) begin
            data = WrData;
        end else begin
            data = m[k][addr];
`ifdef REGFILE_PARITY_CHECK_EN
            pe = ((^m[k][addr]) != mp[k][addr]);
`endif
        end
    endtask

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                for (int i = 0; i < 16; i++) begin
                    m[k][i]  = 8'h00;
                    mp[k][i] = 1'b0;
                end
                m[k][2]  = 8'h81; mp[k][2] = 1'b0;
                m[k][3]  = 8'h20; mp[k][3] = 1'b1;
                e_rda[k] = 8'h00; e_rdb[k] = 8'h00;
                e_va[k]  = 1'b0;  e_vb[k]  = 1'b0;
                e_aerr[k] = 3'b000; e_perr[k] = 2'b00;
            end else begin
                e_va[k]   = RdEnA;
                e_vb[k]   = RdEnB;
                e_aerr[k] = 3'b000;
                e_perr[k] = 2'b00;
                if (RdEnA) model_read(k, RdAddrA, e_rda[k], e_aerr[k][1], e_perr[k][0]);
                if (RdEnB) model_read(k, RdAddrB, e_rdb[k], e_aerr[k][2], e_perr[k][1]);
                if (WrEn) begin
                    if (int'(WrAddr) < depth[k]) begin
                        m[k][WrAddr]  = WrData;
                        mp[k][WrAddr] = ^WrData;
                    end else begin
                        e_aerr[k][0] = 1'b1;
                    end
                end
            end
        end
        if (RST) mvalid = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("m%0d.RdDataA", k),  32'(rda[k]),  32'(e_rda[k]));
                check($sformatf("m%0d.RdValidA", k), 32'(va[k]),   32'(e_va[k]));
                check($sformatf("m%0d.RdDataB", k),  32'(rdb[k]),  32'(e_rdb[k]));
                check($sformatf("m%0d.RdValidB", k), 32'(vb[k]),   32'(e_vb[k]));
                check($sformatf("m%0d.AddrErr", k),  32'(aerr[k]), 32'(e_aerr[k]));
                check($sformatf("m%0d.ParErr", k),   32'(perr[k]), 32'(e_perr[k]));
                check($sformatf("m%0d.REG_OUT", k),  regout[k],
                      {m[k][3], m[k][2], m[k][1], m[k][0]});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        RST = 1'b0; WrEn = 1'b0; RdEnA = 1'b0; RdEnB = 1'b0;
    endtask

    initial begin
        // 1: reset with every strobe active
        RST = 1'b1; WrEn = 1'b1; WrAddr = 4'h2; WrData = 8'hFF;
        RdEnA = 1'b1; RdAddrA = 4'h2; RdEnB = 1'b1; RdAddrB = 4'h3;
        @(negedge CLK);
        check("rst.REG_OUT", regout[0], 32'h2081_0000);
        check("rst.REG_OUT12", regout[1], 32'h2081_0000);
        check("rst.RdValidA", 32'(va[0]), 32'd0);
        check("rst.RdDataB", 32'(rdb[0]), 32'd0);
        idle();
        @(negedge CLK);
        check("post_rst.valid", 32'({va[0], vb[0]}), 32'd0);
        check("post_rst.AddrErr", 32'(aerr[0]), 32'd0);

        // 2: write then read, latency 1, single pulse
        WrEn = 1'b1; WrAddr = 4'hA; WrData = 8'h88;
        @(negedge CLK);
        idle(); RdEnA = 1'b1; RdAddrA = 4'hA;
        check("t2.valid_before", 32'(va[0]), 32'd0);
        @(negedge CLK);
        check("t2.RdDataA", 32'(rda[0]), 32'h88);
        check("t2.RdValidA", 32'(va[0]), 32'd1);
        idle();
        @(negedge CLK);
        check("t2.pulse_end", 32'(va[0]), 32'd0);
        check("t2.hold", 32'(rda[0]), 32'h88);

        // back-to-back reads of the reset entries
        RdEnA = 1'b1; RdAddrA = 4'h2;
        @(negedge CLK);
        check("b2b.first", 32'(rda[0]), 32'h81);
        RdAddrA = 4'h3;
        @(negedge CLK);
        check("b2b.second", 32'(rda[0]), 32'h20);
        check("b2b.valid", 32'(va[0]), 32'd1);
        idle();

        // 3: same-cycle write + dual read of 0xF (out of range in dut12)
        WrEn = 1'b1; WrAddr = 4'hF; WrData = 8'h8B;
        RdEnA = 1'b1; RdAddrA = 4'hF; RdEnB = 1'b1; RdAddrB = 4'hF;
        @(negedge CLK);
        check("t3.RdDataA", 32'(rda[0]), 32'h8B);
        check("t3.RdDataB", 32'(rdb[0]), 32'h8B);
        check("t3.AddrErr12", 32'(aerr[1]), 32'b111);
        idle(); RdEnA = 1'b1; RdAddrA = 4'hF;
        @(negedge CLK);
        check("t3.later", 32'(rda[0]), 32'h8B);
        idle();

        // 4: out-of-range write/read on dut12
        WrEn = 1'b1; WrAddr = 4'hD; WrData = 8'h55;
        @(negedge CLK);
        check("t4.wr_err12", 32'(aerr[1]), 32'b001);
        check("t4.wr_err16", 32'(aerr[0]), 32'b000);
        idle(); RdEnB = 1'b1; RdAddrB = 4'hD;
        @(negedge CLK);
        check("t4.RdDataB12", 32'(rdb[1]), 32'h00);
        check("t4.RdValidB12", 32'(vb[1]), 32'd1);
        check("t4.AddrErr12", 32'(aerr[1]), 32'b100);
        check("t4.RdDataB16", 32'(rdb[0]), 32'h55);
        idle();

        // 5: export timing and reset during a read strobe
        WrEn = 1'b1; WrAddr = 4'h1; WrData = 8'h3C;
        check("t5.same_cycle", 32'(regout[0][15:8]), 32'h00);
        @(negedge CLK);
        check("t5.next_cycle", 32'(regout[0][15:8]), 32'h3C);
        idle(); RST = 1'b1; RdEnA = 1'b1; RdAddrA = 4'h1;
        WrEn = 1'b1; WrAddr = 4'h4; WrData = 8'h77;
        @(negedge CLK);
        check("t5.rst_valid", 32'(va[0]), 32'd0);
        check("t5.rst_regout", regout[0], 32'h2081_0000);
        idle(); RdEnA = 1'b1; RdAddrA = 4'h4;
        @(negedge CLK);
        check("t5.no_write", 32'(rda[0]), 32'h00);
        idle();

        // 6: parity error injection
        WrEn = 1'b1; WrAddr = 4'h5; WrData = 8'h5A;
        @(negedge CLK);
        idle();
`ifdef REGFILE_PARITY_CHECK_EN
        force dut0.mem_q[5] = 8'h5B;
        m[0][5] = 8'h5B;
`endif
        RdEnA = 1'b1; RdAddrA = 4'h5;
        @(negedge CLK);
`ifdef REGFILE_PARITY_CHECK_EN
        check("t6.flipped", 32'(rda[0]), 32'h5B);
        check("t6.ParErr", 32'(perr[0]), 32'b01);
        release dut0.mem_q[5];
`else
        check("t6.data", 32'(rda[0]), 32'h5A);
        check("t6.ParErr", 32'(perr[0]), 32'b00);
`endif
        idle();
        @(negedge CLK);
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
